// File: rtl/mem_sp_bit_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sp_bit_ctrl
// Initiator for a single-port memory with bit-wise write enables. Accepts client
// requests (single-beat masked writes, incrementing read bursts) and a
// whole-memory zero-fill, drives the memory en/we/addr/din port, and returns
// read data through a 2-entry first-word-fall-through response FIFO.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we                  bit write mask, all-zero selects a read
//   req_addr/req_len        start word address, read burst beats-1
//   req_data                write data
//   init_start              pulse: zero-fill the whole memory
//   init_busy/init_done     fill in progress / 1-cycle pulse at completion
//   rsp_valid/rsp_ready     read response handshake
//   rsp_data/rsp_last       read data, final beat of a burst
//   mem_en/mem_we/mem_addr/mem_din   memory command port
//   mem_dout                memory read data, valid 1 cycle after a read en
// -----------------------------------------------------------------------------
module mem_sp_bit_ctrl #(
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 14,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [MEM_DATAWIDTH-1:0] req_we,
  input  logic [MEM_ADDRWIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]     req_len,
  input  logic [MEM_DATAWIDTH-1:0] req_data,
  input  logic                     init_start,
  output logic                     init_busy,
  output logic                     init_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [MEM_DATAWIDTH-1:0] rsp_data,
  output logic                     rsp_last,
  output logic                     mem_en,
  output logic [MEM_DATAWIDTH-1:0] mem_we,
  output logic [MEM_ADDRWIDTH-1:0] mem_addr,
  output logic [MEM_DATAWIDTH-1:0] mem_din,
  input  logic [MEM_DATAWIDTH-1:0] mem_dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_INIT = 2'd2;

  logic [1:0]               r_state;
  logic                     r_run;        // low in reset and the first cycle after release
  logic [MEM_ADDRWIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]     r_remaining;
  logic [MEM_ADDRWIDTH-1:0] r_fill_addr;
  logic                     r_init_done;
  logic                     r_inflight;
  logic                     r_inflight_last;

  logic [MEM_DATAWIDTH-1:0] r_fifo_data [2];
  logic [1:0]               r_fifo_last;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;

  logic       w_idle;
  logic       w_init_accept;
  logic       w_rd_accept;
  logic       w_wr_issue;
  logic       w_rd_issue;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_occupancy;

  // ---------------------------------------------------------------------------
  // Request acceptance and issue decisions
  // ---------------------------------------------------------------------------
  assign w_idle        = r_run && (r_state == ST_IDLE);
  assign w_init_accept = w_idle && init_start;
  assign req_ready     = w_idle && !init_start;
  assign w_wr_issue    = req_ready && req_valid && (req_we != '0);
  assign w_rd_accept   = req_ready && req_valid && (req_we == '0);

  assign rsp_valid = (r_count != 2'd0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_push    = r_inflight;

  // Slots already claimed after this cycle's pop: FIFO entries plus the beat
  // still in the memory pipeline. A pop (pop implies count>=1) cannot underflow.
  assign w_occupancy = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_rd_issue  = (r_state == ST_READ) && (w_occupancy < 2'd2);

  assign init_busy = (r_state == ST_INIT);
  assign init_done = r_init_done;

  assign rsp_data = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign rsp_last = rsp_valid & r_fifo_last[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // Memory command port
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_wr_issue) begin
      mem_en   = 1'b1;
      mem_we   = req_we;
      mem_addr = req_addr;
      mem_din  = req_data;
    end else if (w_rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = r_cur_addr;
    end else if (r_state == ST_INIT) begin
      mem_en   = 1'b1;
      mem_we   = '1;
      mem_addr = r_fill_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_run           <= 1'b0;
      r_cur_addr      <= '0;
      r_remaining     <= '0;
      r_fill_addr     <= '0;
      r_init_done     <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_run           <= 1'b1;
      r_init_done     <= 1'b0;
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue && (r_remaining == '0);
      case (r_state)
        ST_IDLE: begin
          if (w_init_accept) begin
            r_state     <= ST_INIT;
            r_fill_addr <= '0;
          end else if (w_rd_accept) begin
            r_state     <= ST_READ;
            r_cur_addr  <= req_addr;
            r_remaining <= req_len;
          end
        end
        ST_READ: begin
          if (w_rd_issue) begin
            r_cur_addr  <= r_cur_addr + 1'b1;  // wraps at the top of memory
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == '0) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_INIT: begin
          r_fill_addr <= r_fill_addr + 1'b1;
          if (r_fill_addr == '1) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (2 entries, first-word-fall-through)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_fifo_last <= 2'b00;
    end else begin
      if (w_push) begin
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // NOTE: the data storage has no reset; validity is carried entirely by the
  // reset pointers and count, and rsp_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_dout;
    end
  end

endmodule

// File: doc/mem_sp_bit_ctrl.md
Name: mem_sp_bit_ctrl

Overview:
Initiator for the single-port bit-write-enable memory wrapper. It accepts client requests: single-beat masked writes, incrementing read bursts, and a whole-memory zero-fill. It drives the memory en/we/addr/din port and accounts for the memory's 1-cycle read latency. Read data returns through a 2-entry response FIFO with valid/ready backpressure. Sits between a client (DTU/NoC side) and the memory wrapper.

Parameters:
MEM_DATAWIDTH, 128, data width and bit-wise write-enable width
MEM_ADDRWIDTH, 14, word address width
LEN_WIDTH, 8, width of burst length field (beats-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  MEM_DATAWIDTH  bit write mask; all-zero = read request
req_addr  in  MEM_ADDRWIDTH  start word address
req_len  in  LEN_WIDTH  read burst beats-1 (ignored for writes)
req_data  in  MEM_DATAWIDTH  write data
init_start  in  1  pulse: zero-fill entire memory
init_busy  out  1  high during zero-fill
init_done  out  1  1-cycle pulse after last fill write
rsp_valid  out  1  read data valid
rsp_ready  in  1  client accepts read data
rsp_data  out  MEM_DATAWIDTH  read data
rsp_last  out  1  marks final beat of a burst
mem_en  out  1  to memory en
mem_we  out  MEM_DATAWIDTH  to memory we
mem_addr  out  MEM_ADDRWIDTH  to memory addr
mem_din  out  MEM_DATAWIDTH  to memory din
mem_dout  in  MEM_DATAWIDTH  from memory; valid 1 cycle after read en

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, inflight=0, counters 0. All outputs 0 (req_ready 0 while in reset, 1 in IDLE afterwards).
- States: IDLE, READ, INIT.
- IDLE, init_start=1: enter INIT; init_start has priority over req_valid, and req_ready=0 that cycle. init_start outside IDLE is ignored.
- IDLE, no init_start: req_ready=1.
  - Write (req_valid && req_we!=0): issued combinationally in the same cycle: mem_en=1, mem_we=req_we, mem_addr=req_addr, mem_din=req_data. State stays IDLE, so back-to-back writes run at 1/cycle.
  - Read (req_valid && req_we==0): latch addr and remaining=req_len, go to READ. No memory access in the accept cycle.
- READ: req_ready=0. Each cycle a beat may issue (mem_en=1, mem_we=0, mem_addr=cur_addr) only if fifo_count + inflight - pop < 2, where pop = rsp_valid&&rsp_ready in that cycle. This is a combinational path from rsp_ready to mem_en.
  - On issue: cur_addr+1 mod 2^MEM_ADDRWIDTH (wraps max->0), remaining-1.
  - Beat issued with remaining==0 is the last beat; its tag rsp_last=1 travels with it. State returns to IDLE the next cycle.
- Inflight: 1-bit register, set when a read beat issues. The cycle after issue, mem_dout and the last tag are pushed into the FIFO. Occupancy accounting guarantees push never overflows.
- FIFO: depth 2, first-word-fall-through. rsp_valid = count!=0. Push and pop in the same cycle are allowed, leaving count unchanged. Sustained rsp_ready=1 gives 1 beat/cycle.
- INIT: init_busy=1, req_ready=0. Each cycle: mem_en=1, mem_we=all ones, mem_din=0, mem_addr=fill counter starting at 0. After address 2^MEM_ADDRWIDTH-1 is written, init_done=1 for 1 cycle (the cycle state returns to IDLE, init_busy=0).
- mem_en=0 and mem_we=0 in every cycle without an issued access. mem_addr/mem_din are 0 when idle.
- Reset mid-burst or mid-init: access aborts immediately. FIFO contents and pending beats are discarded. No rsp_valid after reset release until a new read.

Test Plan:
- AW=4, DW=32: write addr 3, we=0x0000FFFF, data 0xAAAA5555; then read len 0 at addr 3 -> mem port shows write then read; one response 0x????5555 (low half written) with rsp_last=1.
- Read addr 2, len 3, rsp_ready=1 -> reads 2,3,4,5 on consecutive cycles; 4 responses back-to-back; rsp_last only on the 4th.
- Same burst with rsp_ready=0 -> exactly 2 mem_en read cycles, then mem_en=0 while FIFO is full. Raise rsp_ready -> remaining 2 beats issued; data in order.
- Read addr 14, len 2 (AW=4) -> mem_addr 14,15,0; rsp_last on the third response.
- init_start and req_valid asserted in the same cycle -> req_ready=0; 16 writes with we=all ones, din=0 to addr 0..15; init_done pulses once; the pending request is accepted afterwards; reading any address returns 0.
- Assert reset during the 2nd beat of a len 7 burst -> outputs go to 0 asynchronously; after release, rsp_valid=0 and req_ready=1.
